bcd_to_binary_converter: RTL
============================

# bcd_to_binary_converter

Sequential BCD-to-binary converter: the inverse of the display path's binary-to-seven-segment converter. It takes a sign flag plus three BCD digits (e.g. a value keyed in on the board), runs a reverse double-dabble over 12 clock cycles, and returns a 10-bit two's-complement result with a start/done handshake. It sits between the digit-entry logic and the processor's I/O register, so user-entered decimals reach the datapath in the same 10-bit format the display path consumes.

## Interface
- No parameters; all widths fixed (3 BCD digits, 10-bit result).
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion; sampled only when busy=0.
- sign_input  input  1  1 = negative value.
- bcd_input_12b  input  12  [11:8] hundreds, [7:4] tens, [3:0] ones; captured on the accepting edge.
- binary_output_10b  output  10  two's-complement result; registered, held until the next completion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when the result is valid.
- digit_error  output  1  a captured digit was >9; valid with done, held with the result.
- overflow  output  1  magnitude was out of 10-bit range and the result is saturated; valid with done, held.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE: if start=1, capture bcd_input_12b into the upper 12 bits of a 24-bit work register (lower 12 bits = 0), capture sign_input, clear the 4-bit shift counter, and go to SHIFT.
- Digit check happens on capture: any digit >9 latches an internal bad-digit flag.
- SHIFT, once per cycle: logical right-shift the 24-bit work register by 1. Then, for each of the three BCD nibbles in the upper 12 bits, if nibble ≥8, subtract 3. Increment the counter. After the 12th shift, go to FINISH.
- After 12 shifts the lower 12 bits hold the magnitude M (0..999).
- FINISH: compute the result, register it, pulse done, return to IDLE.
  - Bad digit: result 0x000, digit_error=1, overflow=0.
  - Non-negative, M>511: result 0x1FF, overflow=1.
  - Negative, M>512: result 0x200, overflow=1.
  - Otherwise: result = M, or (~M+1) truncated to 10 bits if negative; flags 0.
  - Negative zero returns 0x000.
- start while busy=1 is ignored; it is not queued.
- start held high in IDLE begins a new conversion on the edge after done, i.e. back-to-back conversions.
- Flags and binary_output_10b update only in FINISH. They are not cleared by start.

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, work register=0. Outputs: binary_output_10b=0, busy=0, done=0, digit_error=0, overflow=0.
- Deasserting reset_n mid-conversion aborts it; no done pulse is produced for the aborted request.
- Edge E0 accepts start; busy=1 from E0.
- Shifts occur on E1..E12; FINISH is entered after E12.
- E13 registers the result; done=1 and busy=0 for the single cycle following E13.
- Latency: 13 clocks from the accepting edge to done. It is identical for the error, overflow and normal paths.
- Throughput: one conversion per 14 clocks with start held high.

## Test plan
- Reset, then sign=0, bcd=0x255, start one cycle → busy high 13 cycles, done pulse at E13, result 0x0FF, flags 0.
- sign=1, bcd=0x128 → 0x380 (-128). sign=1, bcd=0x512 → 0x200, overflow=0. sign=1, bcd=0x000 → 0x000.
- sign=0, bcd=0x999 → 0x1FF, overflow=1. sign=1, bcd=0x600 → 0x200, overflow=1. Both with 13-cycle latency.
- bcd=0x1A3 → done at E13, result 0x000, digit_error=1, overflow=0. A following valid conversion clears digit_error.
- Mid-conversion: pulse start again at E5 with a different bcd → ignored; the original result appears at E13. Assert reset_n low at E7 → all outputs 0 immediately and no done pulse; a fresh start afterwards converts normally.
- start held high across three different inputs → done pulses spaced 14 clocks apart with the correct results in order.

Source files
------------

// File: rtl/bcd_to_binary_converter.sv
// ---------------------------------------------------------------------------
// bcd_to_binary_converter
//
// Sequential BCD-to-binary converter (reverse double-dabble). Takes a sign
// flag and three BCD digits, shifts them through a 24-bit work register for
// 12 cycles and returns a saturated 10-bit two's-complement result.
//
// Ports:
//   clock              system clock, rising edge
//   reset_n            asynchronous active-low reset
//   start              conversion request, sampled only while idle
//   sign_input         1 = negative value
//   bcd_input_12b      [11:8] hundreds, [7:4] tens, [3:0] ones
//   binary_output_10b  registered result, held until next completion
//   busy               high while a conversion is running
//   done               one-cycle pulse when the result is valid
//   digit_error        a captured digit was > 9 (result forced to 0)
//   overflow           magnitude out of range, result saturated
// ---------------------------------------------------------------------------
module bcd_to_binary_converter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sign_input,
    input  logic [11:0] bcd_input_12b,
    output logic [9:0]  binary_output_10b,
    output logic        busy,
    output logic        done,
    output logic        digit_error,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Counter value during the 12th shift.
    localparam logic [3:0]  LAST_SHIFT = 4'd11;
    localparam logic [11:0] POS_MAX    = 12'd511;
    localparam logic [11:0] NEG_MAX    = 12'd512;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [23:0]  work_q, work_d;
    logic         neg_q, neg_d;
    logic         bad_q, bad_d;
    logic [9:0]   result_q, result_d;
    logic         done_q, done_d;
    logic         derr_q, derr_d;
    logic         ovf_q, ovf_d;

    logic [23:0]  work_shr;
    logic [23:0]  work_adj;
    logic [11:0]  mag;
    logic [9:0]   mag_neg;
    logic         in_bad;

    // Undo the "+3" of forward double-dabble: a nibble that picked up 8 from
    // the digit above it after the shift must lose 3 to stay valid BCD.
    function automatic logic [3:0] adj3(input logic [3:0] nib);
        return (nib >= 4'd8) ? (nib - 4'd3) : nib;
    endfunction

    function automatic logic gt9(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

    assign work_shr = work_q >> 1;
    assign work_adj = {adj3(work_shr[23:20]), adj3(work_shr[19:16]),
                       adj3(work_shr[15:12]), work_shr[11:0]};

    assign in_bad = gt9(bcd_input_12b[11:8]) | gt9(bcd_input_12b[7:4]) |
                    gt9(bcd_input_12b[3:0]);

    // After 12 shifts the binary magnitude sits in the low 12 bits. Negation
    // is only used when M <= 512, so the low 10 bits are sufficient.
    assign mag     = work_q[11:0];
    assign mag_neg = ~mag[9:0] + 10'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        neg_d    = neg_q;
        bad_d    = bad_q;
        result_d = result_q;
        derr_d   = derr_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = {bcd_input_12b, 12'd0};
                    neg_d   = sign_input;
                    bad_d   = in_bad;
                    cnt_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                work_d = work_adj;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (bad_q) begin
                    result_d = 10'h000;
                    derr_d   = 1'b1;
                    ovf_d    = 1'b0;
                end else if (!neg_q && (mag > POS_MAX)) begin
                    result_d = 10'h1FF;
                    derr_d   = 1'b0;
                    ovf_d    = 1'b1;
                end else if (neg_q && (mag > NEG_MAX)) begin
                    result_d = 10'h200;
                    derr_d   = 1'b0;
                    ovf_d    = 1'b1;
                end else begin
                    // Negative zero naturally yields 0 here.
                    result_d = neg_q ? mag_neg : mag[9:0];
                    derr_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            work_q   <= 24'd0;
            neg_q    <= 1'b0;
            bad_q    <= 1'b0;
            result_q <= 10'd0;
            done_q   <= 1'b0;
            derr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            neg_q    <= neg_d;
            bad_q    <= bad_d;
            result_q <= result_d;
            done_q   <= done_d;
            derr_q   <= derr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign binary_output_10b = result_q;
    assign busy              = (state_q != ST_IDLE);
    assign done              = done_q;
    assign digit_error       = derr_q;
    assign overflow          = ovf_q;

endmodule
